// File: rtl/rst_seq_pkg.sv
// rst_seq shared types and defaults.
// State encoding, default sizing and counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_GAP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NUM_OUT_D = 3;
  localparam int HOLD_D    = 16;
  localparam int GAP_D     = 8;
  localparam int ACK_TMO_D = 64;

  function automatic int cnt_w(
    input int h,
    input int g,
    input int a
  );
    int m;
    m = h;
    if (g > m) m = g;
    if (a > m) m = a;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: saturating loadable up-counter.
// Clear wins over load; hit flags cnt == term.
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit
);

  // Count up each edge, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/rst_seq.sv
// rst_seq: ordered per-domain reset release sequencer.
// Define RST_SEQ_ACK_EN to gate each release on a stage acknowledge.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = NUM_OUT_D,
  parameter int HOLD_CYCLES = HOLD_D,
  parameter int GAP_CYCLES  = GAP_D,
  parameter int ACK_TIMEOUT = ACK_TMO_D
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_RST_REQ,
  output logic [NUM_OUT-1:0] RST_OUT,
  output logic               SEQ_DONE
`ifdef RST_SEQ_ACK_EN
  ,
  input  logic [NUM_OUT-1:0] STAGE_ACK,
  output logic               TIMEOUT_ERR
`endif
);

  localparam int CNT_W =
    cnt_w(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int IDX_W = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0] HOLD_T =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_T =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_OUT - 1);

  state_t             state, state_n;
  logic [NUM_OUT-1:0] rst_out, out_n;
  logic               seq_done, done_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               clr;
  logic [CNT_W-1:0]   cnt;
  logic               hit;
  logic               gap_done;

  rst_seq_cnt #(.W(CNT_W)) u_seq_cnt (
    .clk    (CLK),
    .rst    (RST),
    .clr    (clr),
    .ld     (1'b0),
    .ld_val ('0),
    .term   (HOLD_T),
    .cnt    (cnt),
    .hit    (hit)
  );

  assign gap_done = (cnt >= GAP_T);

`ifdef RST_SEQ_ACK_EN
  localparam logic [IDX_W-1:0] ALL =
    IDX_W'(NUM_OUT);
  localparam logic [CNT_W-1:0] ACK_T =
    CNT_W'(ACK_TIMEOUT - 1);

  logic             tmo_err, err_n;
  logic             ack_seen, seen_n;
  logic             aclr;
  logic [CNT_W-1:0] acnt;
  logic             ahit;
  logic             ack_cur;
  logic             tmo_hit;
  logic             ack_ok;

  rst_seq_cnt #(.W(CNT_W)) u_ack_cnt (
    .clk    (CLK),
    .rst    (RST),
    .clr    (aclr),
    .ld     (1'b0),
    .ld_val ('0),
    .term   (ACK_T),
    .cnt    (acnt),
    .hit    (ahit)
  );

  // Select the acknowledge of the most recently released stage.
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NUM_OUT; i++)
      if (idx == IDX_W'(i + 1)) ack_cur = STAGE_ACK[i];
  end

  assign tmo_hit = ahit & ~ack_seen & ~ack_cur;
  assign ack_ok  = ack_seen | ack_cur | tmo_hit;
  assign TIMEOUT_ERR = tmo_err;
`endif

  // Next-state, release and done decode.
  always_comb begin
    state_n = state;
    out_n   = rst_out;
    done_n  = seq_done;
    idx_n   = idx;
    clr     = 1'b0;
`ifdef RST_SEQ_ACK_EN
    err_n   = tmo_err;
    seen_n  = ack_seen;
    aclr    = 1'b0;
`endif
    if (SW_RST_REQ) begin
      state_n = S_HOLD;
      out_n   = '1;
      done_n  = 1'b0;
      idx_n   = '0;
      clr     = 1'b1;
`ifdef RST_SEQ_ACK_EN
      err_n   = 1'b0;
      seen_n  = 1'b0;
      aclr    = 1'b1;
`endif
    end else begin
      unique case (state)
        S_HOLD: begin
          out_n  = '1;
          done_n = 1'b0;
          if (hit) begin
            out_n[0] = 1'b0;
            idx_n    = IDX_W'(1);
            clr      = 1'b1;
`ifdef RST_SEQ_ACK_EN
            aclr     = 1'b1;
            seen_n   = 1'b0;
            state_n  = S_GAP;
`else
            if (NUM_OUT > 1) begin
              state_n = S_GAP;
            end else begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
`endif
          end
        end
        S_GAP: begin
`ifdef RST_SEQ_ACK_EN
          seen_n = ack_seen | ack_cur;
          err_n  = tmo_err | tmo_hit;
          if (tmo_hit) seen_n = 1'b1;
          if (gap_done && ack_ok) begin
            clr    = 1'b1;
            aclr   = 1'b1;
            seen_n = 1'b0;
            if (idx == ALL) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end else begin
              for (int i = 0; i < NUM_OUT; i++)
                if (idx == IDX_W'(i)) out_n[i] = 1'b0;
              idx_n = idx + 1'b1;
            end
          end
`else
          if (gap_done) begin
            clr = 1'b1;
            for (int i = 0; i < NUM_OUT; i++)
              if (idx == IDX_W'(i)) out_n[i] = 1'b0;
            idx_n = idx + 1'b1;
            if (idx == LAST) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
          end
`endif
        end
        S_DONE: begin
          out_n  = '0;
          done_n = 1'b1;
        end
        default: begin
          state_n = S_HOLD;
          out_n   = '1;
          done_n  = 1'b0;
          idx_n   = '0;
          clr     = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; RST overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_HOLD;
      rst_out  <= '1;
      seq_done <= 1'b0;
      idx      <= '0;
`ifdef RST_SEQ_ACK_EN
      tmo_err  <= 1'b0;
      ack_seen <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      rst_out  <= out_n;
      seq_done <= done_n;
      idx      <= idx_n;
`ifdef RST_SEQ_ACK_EN
      tmo_err  <= err_n;
      ack_seen <= seen_n;
`endif
    end
  end

  assign RST_OUT  = rst_out;
  assign SEQ_DONE = seq_done;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of the reset release sequencer.
// Covers both default and RST_SEQ_ACK_EN builds.
module tb_rst_seq;

  logic       CLK_tb = 1'b0;
  logic       rst;
  logic       sw;
  logic [2:0] out3;
  logic       done3;
  logic [0:0] out1;
  logic       done1;
  int         checks = 0;
  int         errors = 0;

`ifdef RST_SEQ_ACK_EN
  logic [2:0] ack;
  logic       err;
  logic       err1;
  localparam logic D1E1 = 1'b0;
  localparam logic D32  = 1'b0;
`else
  localparam logic D1E1 = 1'b1;
  localparam logic D32  = 1'b1;
`endif

  always #5 CLK_tb = ~CLK_tb;

  rst_seq dut (
    .CLK        (CLK_tb),
    .RST        (rst),
    .SW_RST_REQ (sw),
    .RST_OUT    (out3),
    .SEQ_DONE   (done3)
`ifdef RST_SEQ_ACK_EN
    ,
    .STAGE_ACK  (ack),
    .TIMEOUT_ERR(err)
`endif
  );

  rst_seq #(
    .NUM_OUT    (1),
    .HOLD_CYCLES(1),
    .GAP_CYCLES (1)
  ) dut1 (
    .CLK        (CLK_tb),
    .RST        (rst),
    .SW_RST_REQ (sw),
    .RST_OUT    (out1),
    .SEQ_DONE   (done1)
`ifdef RST_SEQ_ACK_EN
    ,
    .STAGE_ACK  (1'b1),
    .TIMEOUT_ERR(err1)
`endif
  );

  typedef struct {
    int         n;
    logic       rst;
    logic [2:0] exp_out;
    logic       exp_done;
    logic       exp_out1;
    logic       exp_done1;
  } vec_t;

  task automatic step(input int n);
    repeat (n) @(posedge CLK_tb);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  vec_t vt[8];

  initial begin
    rst = 1'b1;
    sw  = 1'b0;
`ifdef RST_SEQ_ACK_EN
    ack = 3'b111;
`endif
    vt[0] = '{3,  1'b1, 3'b111, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1,  1'b0, 3'b111, 1'b0, 1'b0, D1E1};
    vt[2] = '{14, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1,  1'b0, 3'b110, 1'b0, 1'b0, 1'b1};
    vt[4] = '{7,  1'b0, 3'b110, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1,  1'b0, 3'b100, 1'b0, 1'b0, 1'b1};
    vt[6] = '{8,  1'b0, 3'b000, D32,  1'b0, 1'b1};
    vt[7] = '{10, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst;
      step(vt[i].n);
      chk($sformatf("tbl%0d_out", i), 32'(out3),
          32'(vt[i].exp_out));
      chk($sformatf("tbl%0d_done", i), 32'(done3),
          32'(vt[i].exp_done));
      chk($sformatf("tbl%0d_out1", i), 32'(out1),
          32'(vt[i].exp_out1));
      chk($sformatf("tbl%0d_done1", i), 32'(done1),
          32'(vt[i].exp_done1));
    end

    // software reset pulse at edge 20
    do_reset();
    step(19);
    chk("sw_pre_out", 32'(out3), 32'(3'b110));
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    chk("sw_out", 32'(out3), 32'(3'b111));
    chk("sw_done", 32'(done3), 32'(1'b0));
    step(15);
    chk("sw_hold15", 32'(out3), 32'(3'b111));
    step(1);
    chk("sw_rel0", 32'(out3), 32'(3'b110));

    // software reset held for several edges
    sw = 1'b1;
    step(4);
    chk("swh_out", 32'(out3), 32'(3'b111));
    sw = 1'b0;
    step(15);
    chk("swh_hold15", 32'(out3), 32'(3'b111));
    step(1);
    chk("swh_rel0", 32'(out3), 32'(3'b110));

    // RST asserted at edge 28 mid-sequence
    do_reset();
    step(27);
    chk("rst_pre_out", 32'(out3), 32'(3'b100));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_out", 32'(out3), 32'(3'b111));
    chk("rst_done", 32'(done3), 32'(1'b0));
    step(16);
    chk("rst_rel0", 32'(out3), 32'(3'b110));
    step(8);
    chk("rst_rel1", 32'(out3), 32'(3'b100));
    step(8);
    chk("rst_rel2", 32'(out3), 32'(3'b000));
    chk("rst_done32", 32'(done3), 32'(D32));
    step(8);
    chk("rst_done_late", 32'(done3), 32'(1'b1));

`ifdef RST_SEQ_ACK_EN
    // late acknowledge delays release of stage 1
    ack = 3'b000;
    do_reset();
    step(16);
    chk("ack_rel0", 32'(out3), 32'(3'b110));
    step(23);
    chk("ack_wait39", 32'(out3), 32'(3'b110));
    ack = 3'b001;
    step(1);
    chk("ack_rel1", 32'(out3), 32'(3'b100));
    chk("ack_err0", 32'(err), 32'(1'b0));
    ack = 3'b111;
    step(8);
    chk("ack_rel2", 32'(out3), 32'(3'b000));
    chk("ack_done48", 32'(done3), 32'(1'b0));
    step(8);
    chk("ack_done56", 32'(done3), 32'(1'b1));
    chk("ack_err_end", 32'(err), 32'(1'b0));
    chk("ack_err1", 32'(err1), 32'(1'b0));

    // acknowledge never arrives
    ack = 3'b000;
    do_reset();
    step(79);
    chk("tmo_pre_out", 32'(out3), 32'(3'b110));
    chk("tmo_pre_err", 32'(err), 32'(1'b0));
    step(1);
    chk("tmo_out", 32'(out3), 32'(3'b100));
    chk("tmo_err", 32'(err), 32'(1'b1));
    step(5);
    chk("tmo_sticky", 32'(err), 32'(1'b1));
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    chk("tmo_clr", 32'(err), 32'(1'b0));
    chk("tmo_sw_out", 32'(out3), 32'(3'b111));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
